decoder_nto1hot_pipe: RTL and testbench
=======================================

// Module: decoder_nto1hot_pipe
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder with a valid/ready output stage.
//  Used as the LC-3 register-file write-select generator.
//  SCAN mode walks a one-hot through all outputs, one per accepted beat, to clear or initialise the register file.
//  Sits between the control FSM (code, start) and the register-file write-enable inputs.
// PARAMETERS
//  IN_W   3   width of binary code input
//  OUT_N  8   number of one-hot outputs; 2 <= OUT_N <= 2**IN_W
// PORTS
//  clk         in   1       rising-edge clock, the only clock
//  rst         in   1       asynchronous, active-high reset
//  in_valid    in   1       d_in is valid this cycle
//  in_ready    out  1       block accepts d_in this cycle
//  d_in        in   IN_W    binary code to decode
//  scan_start  in   1       one-cycle request to start a sweep
//  scan_busy   out  1       high while the sweep FSM is in SCAN
//  scan_done   out  1       one-cycle pulse after the last sweep beat is loaded
//  out_valid   out  1       d_out / d_code hold a beat
//  out_ready   in   1       downstream accepts the beat
//  d_out       out  OUT_N   one-hot word (all-zero for an out-of-range code)
//  d_code      out  IN_W    binary code that produced d_out
//  err         out  1       only with DEC_RANGE_ERR_EN: beat's code >= OUT_N
// BEHAVIOUR
//  Reset (async): out_valid=0, d_out=0, d_code=0, err=0, scan_busy=0, scan_done=0, state=IDLE, scan_cnt=0.
//  Define load = !out_valid || out_ready. The output register loads only when load=1.
//  out_valid/d_out/d_code hold stable while out_valid && !out_ready.
//  IDLE: in_ready = load && !scan_start. This is combinational and does not depend on in_valid.
//  IDLE, in_valid && in_ready: next edge d_out[i] = (d_in == i), d_code = d_in, out_valid = 1. Latency is 1 clock.
//  IDLE, load && !(in_valid && in_ready): out_valid goes to 0.
//  Code >= OUT_N: d_out = 0, out_valid = 1. The beat is still emitted.
//  scan_start in IDLE has priority over in_valid in the same cycle: in_ready=0, go to SCAN, scan_cnt=0.
//  SCAN: in_ready=0 and scan_busy=1.
//    Each cycle with load=1: load a beat with d_out = one-hot(scan_cnt), d_code = scan_cnt, out_valid = 1; then scan_cnt++.
//    When the loaded beat is scan_cnt == OUT_N-1: next state is IDLE and scan_done pulses for one cycle (the cycle after the load).
//    scan_cnt wraps to 0.
//    Stall (load=0): scan_cnt and the output register hold. No beat is skipped or duplicated.
//  scan_start while in SCAN is ignored. A sweep is never restarted.
//  Back-to-back: in the cycle scan_done is high the FSM is IDLE, so in_ready may be 1.
//  Arithmetic: scan_cnt is IN_W bits, compared against OUT_N-1 at width IN_W. One-hot is built as a compare per output bit, with no shifter wider than OUT_N.
//  Reset mid-scan or mid-stall: everything returns to reset values immediately. A pending beat is lost.
// CONFIGURATION
//  DEC_RANGE_ERR_EN defined:
//    err port exists. It is registered with d_out and set to (code >= OUT_N) on each load.
//    err is held while stalled. It is never set by a scan beat.
//  DEC_RANGE_ERR_EN undefined:
//    No err port and no compare logic.
//    An out-of-range code silently yields d_out = 0 with out_valid = 1.
// STRUCTURE
//  Package dec_pkg:
//    typedef enum {DEC_IDLE, DEC_SCAN} dec_state_t
//    function onehot(code, n) returning the n-bit one-hot word
//  Sub-module dec_out_reg: valid/ready output register (d_out, d_code, err, out_valid).
//  The top level holds the FSM, scan_cnt and the input mux.
// TESTING
//  Use IN_W=3, OUT_N=6 unless noted.
//  1. Reset, out_ready=1, d_in=0..5 one per cycle with in_valid=1
//     -> d_out = 01,02,04,08,10,20 one clock later each; out_valid held 1; d_code matches.
//  2. d_in=6 then 7
//     -> d_out=00 with out_valid=1; with DEC_RANGE_ERR_EN, err=1 on exactly those beats.
//  3. Load d_in=2, then out_ready=0 for 3 cycles with in_valid=1, d_in=4
//     -> d_out holds 04 (d_in=2 decoded) and in_ready=0 for all 3 cycles; d_out=10 (d_in=4 decoded) after release.
//  4. scan_start and in_valid high in the same cycle, with out_ready toggling 1,0,1,...
//     -> beats 01,02,04,08,10,20 in order, no gaps or duplicates;
//     -> in_ready=0 throughout; scan_busy=1 throughout; scan_done pulses once, after beat 20;
//     -> second scan_start mid-sweep is ignored.
//  5. Assert rst mid-sweep after beat 04
//     -> all outputs 0 asynchronously; a new scan_start then begins again at 01.
//  6. OUT_N=8 (IN_W=3)
//     -> d_in=7 gives 80 with err=0; a full sweep gives 8 beats ending at 80.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and helpers for the binary-to-one-hot decoder.
//   dec_state_t : sweep FSM states (IDLE accepts codes, SCAN walks all outputs)
//   onehot()    : per-bit compare decoder; callers truncate to their OUT_N
package dec_pkg;

  // Widest one-hot word the helper can produce.
  localparam int unsigned DEC_MAX_N = 256;

  typedef enum logic {DEC_IDLE, DEC_SCAN} dec_state_t;

  // Bit i is set when code == i and i < n; codes >= n give an all-zero word.
  function automatic logic [DEC_MAX_N-1:0] onehot(input logic [31:0] code,
                                                  input int unsigned n);
    logic [DEC_MAX_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DEC_MAX_N; i++) begin
      r[i] = (i < n) && (code == i);
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_nto1hot_pipe_out_reg.sv
// dec_out_reg: valid/ready output register of the decoder.
//   clk, rst        clock, asynchronous active-high reset
//   ld_en           register may update this cycle (downstream can take a beat)
//   ld_valid        a new beat is presented; when 0 the register only drops out_valid
//   ld_onehot/code  beat payload
//   ld_err/err      range-error flag, present only with DEC_RANGE_ERR_EN
//   out_valid, d_out, d_code  registered beat
module dec_out_reg #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             ld_valid,
  input  logic [OUT_N-1:0] ld_onehot,
  input  logic [IN_W-1:0]  ld_code,
`ifdef DEC_RANGE_ERR_EN
  input  logic             ld_err,
  output logic             err,
`endif
  output logic             out_valid,
  output logic [OUT_N-1:0] d_out,
  output logic [IN_W-1:0]  d_code
);

  // Payload only changes when a real beat is loaded; an empty load just
  // clears out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      d_code    <= '0;
    end else if (ld_en) begin
      out_valid <= ld_valid;
      if (ld_valid) begin
        d_out  <= ld_onehot;
        d_code <= ld_code;
      end
    end
  end

`ifdef DEC_RANGE_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ld_en && ld_valid) begin
      err <= ld_err;
    end
  end
`endif

endmodule

// File: rtl/decoder_nto1hot_pipe.sv
// decoder_nto1hot_pipe: registered binary-to-one-hot decoder with a
// valid/ready output stage and a SCAN sweep that walks a one-hot through
// every output (register-file write-select generator).
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready/d_in  input code handshake (in_ready ignores in_valid)
//   scan_start            one-cycle sweep request (ignored while sweeping)
//   scan_busy             FSM is in SCAN
//   scan_done             one-cycle pulse after the last sweep beat is loaded
//   out_valid/out_ready   output handshake
//   d_out, d_code         one-hot word and the code that produced it
//   err                   code >= OUT_N for the held beat (DEC_RANGE_ERR_EN only)
// Optional feature macro: DEC_RANGE_ERR_EN
module decoder_nto1hot_pipe
  import dec_pkg::*;
#(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  d_in,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] d_out,
  output logic [IN_W-1:0]  d_code
`ifdef DEC_RANGE_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [IN_W-1:0] LAST_CODE = IN_W'(OUT_N - 1);

  dec_state_t      state, state_n;
  logic [IN_W-1:0] scan_cnt, scan_cnt_n;
  logic            scan_done_n;

  logic             load;
  logic             ld_valid;
  logic [IN_W-1:0]  ld_code;
  logic [OUT_N-1:0] ld_onehot;
`ifdef DEC_RANGE_ERR_EN
  logic             ld_err;
`endif

  assign load      = !out_valid || out_ready;
  assign scan_busy = (state == DEC_SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DEC_IDLE;
      scan_cnt  <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_n;
      scan_cnt  <= scan_cnt_n;
      scan_done <= scan_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    scan_cnt_n  = scan_cnt;
    scan_done_n = 1'b0;
    in_ready    = 1'b0;
    ld_valid    = 1'b0;
    ld_code     = d_in;
`ifdef DEC_RANGE_ERR_EN
    ld_err      = 1'b0;
`endif
    unique case (state)
      DEC_IDLE: begin
        // A sweep request wins over a same-cycle input code.
        in_ready = load && !scan_start;
        ld_valid = in_valid && in_ready;
`ifdef DEC_RANGE_ERR_EN
        ld_err   = (32'(d_in) >= OUT_N);
`endif
        if (scan_start) begin
          state_n    = DEC_SCAN;
          scan_cnt_n = '0;
        end
      end
      DEC_SCAN: begin
        ld_valid = 1'b1;
        ld_code  = scan_cnt;
        // The counter only moves when its beat is actually loaded, so a
        // stall can neither skip nor repeat a sweep position.
        if (load) begin
          if (scan_cnt == LAST_CODE) begin
            state_n     = DEC_IDLE;
            scan_cnt_n  = '0;
            scan_done_n = 1'b1;
          end else begin
            scan_cnt_n = scan_cnt + IN_W'(1);
          end
        end
      end
      default: state_n = DEC_IDLE;
    endcase
    ld_onehot = OUT_N'(onehot(32'(ld_code), OUT_N));
  end

  dec_out_reg #(
    .IN_W  (IN_W),
    .OUT_N (OUT_N)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (load),
    .ld_valid  (ld_valid),
    .ld_onehot (ld_onehot),
    .ld_code   (ld_code),
`ifdef DEC_RANGE_ERR_EN
    .ld_err    (ld_err),
    .err       (err),
`endif
    .out_valid (out_valid),
    .d_out     (d_out),
    .d_code    (d_code)
  );

endmodule

// File: tb/tb_decoder_nto1hot_pipe.sv
// Self-checking bench for decoder_nto1hot_pipe (IN_W=3, OUT_N=6 main
// instance; OUT_N=8 second instance). Honours DEC_RANGE_ERR_EN if defined.
module tb_decoder_nto1hot_pipe;

  localparam int unsigned IN_W = 3;
  localparam int unsigned N6   = 6;
  localparam int unsigned N8   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // OUT_N = 6 instance
  logic            in_valid, in_ready, scan_start, scan_busy, scan_done;
  logic            out_valid, out_ready;
  logic [IN_W-1:0] d_in, d_code;
  logic [N6-1:0]   d_out;
`ifdef DEC_RANGE_ERR_EN
  logic            err;
`endif

  // OUT_N = 8 instance
  logic            iv8, ir8, ss8, busy8, done8, ov8, or8;
  logic [IN_W-1:0] d8, code8;
  logic [N8-1:0]   dout8;
`ifdef DEC_RANGE_ERR_EN
  logic            err8;
`endif

  decoder_nto1hot_pipe #(.IN_W(IN_W), .OUT_N(N6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .d_code(d_code)
`ifdef DEC_RANGE_ERR_EN
    , .err(err)
`endif
  );

  decoder_nto1hot_pipe #(.IN_W(IN_W), .OUT_N(N8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .d_in(d8),
    .scan_start(ss8), .scan_busy(busy8), .scan_done(done8),
    .out_valid(ov8), .out_ready(or8), .d_out(dout8), .d_code(code8)
`ifdef DEC_RANGE_ERR_EN
    , .err(err8)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output beat as (valid, code, err), the sweep as
  // a position counter; the one-hot word is derived arithmetically.
  bit m_valid, m_scan, m_done, m_err;
  int m_code, m_cnt;

  function automatic logic [63:0] exp_onehot(input int code);
    return (code < N6) ? (64'd1 << code) : 64'd0;
  endfunction

  function automatic bit exp_in_ready();
    return !m_scan && (!m_valid || out_ready) && !scan_start;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_scan = 0; m_done = 0; m_err = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit room, take;
    room   = !m_valid || out_ready;
    m_done = 0;
    if (!m_scan) begin
      take = in_valid && room && !scan_start;
      if (scan_start) begin
        m_scan = 1;
        m_cnt  = 0;
      end
      if (room) begin
        m_valid = take;
        if (take) begin
          m_code = int'(d_in);
          m_err  = (int'(d_in) >= N6);
        end
      end
    end else if (room) begin
      m_valid = 1;
      m_code  = m_cnt;
      m_err   = 0;
      if (m_cnt == N6 - 1) begin
        m_scan = 0;
        m_cnt  = 0;
        m_done = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Compare the current cycle against the model, then advance one clock.
  task automatic cycle();
    #1;
    check("in_ready", in_ready, exp_in_ready());
    check("scan_busy", scan_busy, m_scan);
    check("scan_done", scan_done, m_done);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("d_out", d_out, exp_onehot(m_code));
      check("d_code", d_code, m_code);
`ifdef DEC_RANGE_ERR_EN
      check("err", err, m_err);
`endif
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; d_in = '0; scan_start = 0; out_ready = 1;
    iv8 = 0; d8 = '0; ss8 = 0; or8 = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #2;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_d_out", d_out, 0);
    check("rst_d_code", d_code, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_done", scan_done, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    int            code;
    logic [N6-1:0] exp_out;
    bit            exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [N6-1:0] beats[$];
  logic [N8-1:0] beats8[$];

  initial begin
    vecs[0] = '{0, 6'h01, 1'b0};
    vecs[1] = '{1, 6'h02, 1'b0};
    vecs[2] = '{2, 6'h04, 1'b0};
    vecs[3] = '{3, 6'h08, 1'b0};
    vecs[4] = '{4, 6'h10, 1'b0};
    vecs[5] = '{5, 6'h20, 1'b0};
    vecs[6] = '{6, 6'h00, 1'b1};
    vecs[7] = '{7, 6'h00, 1'b1};

    do_reset();

    // Back-to-back codes, including out-of-range ones.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; d_in = IN_W'(vecs[i].code); out_ready = 1;
      cycle();
      check("tbl_valid", out_valid, 1);
      check("tbl_d_out", d_out, vecs[i].exp_out);
      check("tbl_d_code", d_code, vecs[i].code);
`ifdef DEC_RANGE_ERR_EN
      check("tbl_err", err, vecs[i].exp_err);
`endif
    end

    // Stall holds the beat and blocks input.
    in_valid = 1; d_in = 3'd2; out_ready = 1;
    cycle();
    d_in = 3'd4; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", in_ready, 0);
      check("stall_d_out", d_out, 6'h04);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1;
    cycle();
    check("release_d_out", d_out, 6'h10);
    in_valid = 0;
    cycle();

    // Sweep with toggling out_ready and a second scan_start mid-sweep.
    begin
      int  done_cnt;
      bit  seen_done;
      done_cnt = 0; seen_done = 0;
      beats.delete();
      in_valid = 1; d_in = 3'd5; scan_start = 1; out_ready = 1;
      cycle();
      in_valid = 0;
      for (int k = 0; k < 40 && !(beats.size() >= N6 && seen_done); k++) begin
        out_ready  = (k % 2 == 1);
        scan_start = (k == 4);
        #1;
        if (scan_busy) check("scan_in_ready", in_ready, 0);
        if (scan_done) begin
          done_cnt++;
          if (!seen_done) check("done_after_last", d_out, 6'h20);
          seen_done = 1;
        end
        if (out_valid && out_ready) beats.push_back(d_out);
        cycle();
      end
      scan_start = 0; out_ready = 1;
      for (int k = 0; k < 4; k++) begin
        #1;
        if (scan_done) done_cnt++;
        if (out_valid && out_ready) beats.push_back(d_out);
        cycle();
      end
      check("sweep_len", beats.size(), N6);
      for (int i = 0; i < beats.size(); i++) check("sweep_beat", beats[i], 64'd1 << i);
      check("done_pulses", done_cnt, 1);
    end

    // Asynchronous reset mid-sweep, then a fresh sweep restarts at 01.
    begin
      bit found;
      found = 0;
      scan_start = 1; out_ready = 1;
      cycle();
      scan_start = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        cycle();
        if (out_valid && d_out == 6'h04) found = 1;
      end
      check("wait_beat_04", found, 1);
      #2;
      rst = 1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_d_out", d_out, 0);
      check("arst_d_code", d_code, 0);
      check("arst_busy", scan_busy, 0);
      check("arst_done", scan_done, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      model_step();
      #1;
      scan_start = 1;
      cycle();
      scan_start = 0;
      cycle();
      check("restart_first", d_out, 6'h01);
      check("restart_valid", out_valid, 1);
      for (int k = 0; k < 8; k++) cycle();
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid   = 1'($urandom_range(0, 1));
      d_in       = IN_W'($urandom_range(0, 7));
      out_ready  = ($urandom_range(0, 3) != 0);
      scan_start = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    // OUT_N = 8: top code and a full 8-beat sweep.
    iv8 = 1; d8 = 3'd7; or8 = 1;
    @(posedge clk); model_step(); #1;
    iv8 = 0;
    check("n8_valid", ov8, 1);
    check("n8_d_out", dout8, 8'h80);
    check("n8_d_code", code8, 7);
`ifdef DEC_RANGE_ERR_EN
    check("n8_err", err8, 0);
`endif
    ss8 = 1;
    @(posedge clk); model_step(); #1;
    ss8 = 0;
    beats8.delete();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); model_step(); #1;
      if (ov8) beats8.push_back(dout8);
      if (done8) break;
    end
    check("n8_sweep_len", beats8.size(), N8);
    for (int i = 0; i < beats8.size(); i++) check("n8_sweep_beat", beats8[i], 64'd1 << i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
